mdu_ctrl: RTL

- Sequencer and owner of the multiply/divide unit and the HI/LO registers for the five-stage MIPS pipeline.
- Accepts MDU operations from the Execute stage and models the fixed multiply and divide latencies with a busy counter.
- Commits results to HI/LO and produces the stall request that holds Decode while an instruction flagged by Decode's mlu_use would collide with an MDU operation in flight.

---
 rtl/mdu_ctrl_pkg.sv | 37 +++
 rtl/mdu_ctrl_if.sv | 29 ++
 rtl/mdu_ctrl_alu.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: opcode width and encodings, FSM state type, op-class helpers.
// The accumulate opcodes (MADD..MSUBU) are only honoured when MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd10;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd11;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } mdu_state_e;

  // Callers pass an already-sanitised opcode, so accumulate ops appear only when enabled.
  function automatic logic op_is_mul(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic op_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute/Decode-side connection to the MDU sequencer, plus HI/LO and FSM state visibility.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  // e_valid qualifies e_md_op/e_rs/e_rt for one cycle; the MDU accepts an op only when
  // !busy, and the pipeline must hold Decode whenever stall_d is high (no backpressure else).
  logic [MD_OP_W-1:0] e_md_op;
  logic               e_valid;
  logic [31:0]        e_rs;
  logic [31:0]        e_rt;
  logic               d_mlu_use;
  logic               start;
  logic               busy;
  logic               stall_d;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        md_rd;
  mdu_state_e         dbg_state;

  modport master (
    output e_md_op, e_valid, e_rs, e_rt, d_mlu_use,
    input  start, busy, stall_d, hi, lo, md_rd, dbg_state
  );

  modport slave (
    input  e_md_op, e_valid, e_rs, e_rt, d_mlu_use,
    output start, busy, stall_d, hi, lo, md_rd, dbg_state
  );
endinterface

// File: rtl/mdu_ctrl_alu.sv
// Combinational MDU datapath: 64-bit {hi,lo} result from the latched op and operands.
// With MDU_MADD_EN defined the accumulate ops and their 64-bit adder are built.
module mdu_ctrl_alu
  import mdu_ctrl_pkg::*;
(
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        rs_i,
  input  logic [31:0]        rt_i,
`ifdef MDU_MADD_EN
  input  logic [63:0]        acc_i,
`endif
  output logic [63:0]        res_o,
  output logic               we_o
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic        [31:0] divisor;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;
  logic               s_ovf;

  assign s_prod = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign u_prod = {32'd0, rs_i} * {32'd0, rt_i};

  // Divisor of 1 for /0 and INT_MIN/-1 keeps the divider defined; INT_MIN/1 is the wanted answer.
  assign s_ovf   = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
  assign divisor = ((rt_i == 32'd0) || s_ovf) ? 32'd1 : rt_i;
  assign s_quo   = $signed(rs_i) / $signed(divisor);
  assign s_rem   = $signed(rs_i) % $signed(divisor);
  assign u_quo   = rs_i / divisor;
  assign u_rem   = rs_i % divisor;

  always_comb begin
    res_o = 64'd0;
    we_o  = 1'b1;
    case (op_i)
      MD_MULT:  res_o = s_prod;
      MD_MULTU: res_o = u_prod;
      MD_DIV: begin
        res_o = {s_rem, s_quo};
        we_o  = (rt_i != 32'd0);
      end
      MD_DIVU: begin
        res_o = {u_rem, u_quo};
        we_o  = (rt_i != 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res_o = acc_i + s_prod;
      MD_MADDU: res_o = acc_i + u_prod;
      MD_MSUB:  res_o = acc_i - s_prod;
      MD_MSUBU: res_o = acc_i - u_prod;
`endif
      default:  we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: busy-counter FSM modelling mult/div latency, HI/LO ownership, Decode stall.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU with the multiply latency.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [MD_OP_W-1:0] op_q, op_d;
  logic [31:0]        rs_q, rs_d, rt_q, rt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [MD_OP_W-1:0] op_eff;
  logic               busy, start, commit, alu_we;
  logic [63:0]        alu_res;

  // Unknown opcodes, and accumulate ops when compiled out, collapse to NONE.
  always_comb begin
    op_eff = MD_NONE;
    case (bus.e_md_op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO:   op_eff = bus.e_md_op;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: op_eff = bus.e_md_op;
`endif
      default:                              op_eff = MD_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:                  if (start) state_d = op_is_div(op_eff) ? ST_DIV_BUSY : ST_MUL_BUSY;
      ST_MUL_BUSY, ST_DIV_BUSY: if (cnt_q == 4'd0) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    start  = bus.e_valid && (op_is_mul(op_eff) || op_is_div(op_eff)) && !busy;
    commit = busy && (cnt_q == 4'd0);
  end

  assign bus.start     = start;
  assign bus.busy      = busy;
  assign bus.stall_d   = bus.d_mlu_use && (start || busy);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.md_rd     = (bus.e_md_op == MD_MFHI) ? hi_q :
                         (bus.e_md_op == MD_MFLO) ? lo_q : 32'd0;
  assign bus.dbg_state = state_q;

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    rs_d  = rs_q;
    rt_d  = rt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (start) begin
      cnt_d = op_is_div(op_eff) ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
      op_d  = op_eff;
      rs_d  = bus.e_rs;
      rt_d  = bus.e_rt;
    end else if (busy && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit && alu_we) begin
      {hi_d, lo_d} = alu_res;
    end else if (bus.e_valid && !busy) begin
      if (op_eff == MD_MTHI) hi_d = bus.e_rs;
      if (op_eff == MD_MTLO) lo_d = bus.e_rs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
      op_q  <= MD_NONE;
      rs_q  <= 32'd0;
      rt_q  <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

`ifdef MDU_MADD_EN
  // Accumulator snapshot of HI/LO taken at the start edge.
  logic [63:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     acc_q <= 64'd0;
    else if (start) acc_q <= {hi_q, lo_q};
  end

  mdu_ctrl_alu u_alu (
    .op_i  (op_q),
    .rs_i  (rs_q),
    .rt_i  (rt_q),
    .acc_i (acc_q),
    .res_o (alu_res),
    .we_o  (alu_we)
  );
`else
  mdu_ctrl_alu u_alu (
    .op_i  (op_q),
    .rs_i  (rs_q),
    .rt_i  (rt_q),
    .res_o (alu_res),
    .we_o  (alu_we)
  );
`endif

`ifndef SYNTHESIS
  // Issuing an MDU op or MTHI/MTLO while busy means the Decode stall was not honoured.
  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy && bus.e_valid && (op_is_mul(op_eff) || op_is_div(op_eff) ||
                              (op_eff == MD_MTHI) || (op_eff == MD_MTLO))));
`endif

endmodule
